// File: rtl/fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// fp_add_arbiter
//
// Shares one pipelined floating-point summator between two requesters.
// A requester presents an operand pair with reqK_vld_i. The arbiter grants it
// combinationally through reqK_rdy_o, and registers the granted pair onto the
// summator inputs. A tag shift register carries {valid, requester id}
// alongside the summator's fixed pipeline, so each result returns to its
// owner. The result is strobed for exactly one cycle, with no backpressure.
//
// Timing for a handshake at clock edge T:
//   cycle T+1            : fpu_vld_o = 1, fpu_a_o/fpu_b_o = granted operands
//   cycle T+1+LATENCY    : summator drives the answer on fpu_res_i/fpu_status_i
//   cycle T+LATENCY+2    : respK_vld_o = 1 with resp_res_o/resp_status_o
//
// Parameters
//   LATENCY        cycles from fpu_vld_o to a valid fpu_res_i (must be >= 1)
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   req0_vld_i     requester 0 has an operand pair
//   req0_a_i/b_i   requester 0 operands (IEEE-754 single, 32 bits)
//   req0_rdy_o     grant for requester 0
//   req1_vld_i     requester 1 has an operand pair
//   req1_a_i/b_i   requester 1 operands
//   req1_rdy_o     grant for requester 1
//   resp0_vld_o    one-cycle result strobe for requester 0
//   resp1_vld_o    one-cycle result strobe for requester 1
//   resp_res_o     result, shared by both response channels
//   resp_status_o  summator status belonging to resp_res_o
//   fpu_vld_o      summator vld_i
//   fpu_a_o/b_o    summator a_i / b_i
//   fpu_res_i      summator answer_o
//   fpu_status_i   summator num_status_o
//   busy_o         high while any operation is in flight
//
// Configuration macro
//   FP_ARB_ROUND_ROBIN_EN  when defined, a tie goes to the requester that was
//                          not granted last. When undefined, requester 0
//                          always wins a tie and no last-grant state exists.
// ---------------------------------------------------------------------------
module fp_add_arbiter #(
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_vld_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    output logic        req0_rdy_o,
    input  logic        req1_vld_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic        req1_rdy_o,
    output logic        resp0_vld_o,
    output logic        resp1_vld_o,
    output logic [31:0] resp_res_o,
    output logic [1:0]  resp_status_o,
    output logic        fpu_vld_o,
    output logic [31:0] fpu_a_o,
    output logic [31:0] fpu_b_o,
    input  logic [31:0] fpu_res_i,
    input  logic [1:0]  fpu_status_i,
    output logic        busy_o
);

    // Stage 0 of the tag register lines up with fpu_vld_o.
    // Stage LATENCY lines up with the summator answer.
    localparam int TAG_MSB = LATENCY;

    logic              grant0;
    logic              grant1;
    logic              handshake;
    logic              tieGoesTo0;

    logic              fpuVld_q,   fpuVld_d;
    logic [31:0]       fpuA_q,     fpuA_d;
    logic [31:0]       fpuB_q,     fpuB_d;
    logic [TAG_MSB:0]  tagVld_q,   tagVld_d;
    logic [TAG_MSB:0]  tagId_q,    tagId_d;
    logic              resp0Vld_q, resp0Vld_d;
    logic              resp1Vld_q, resp1Vld_d;
    logic [31:0]       respRes_q,  respRes_d;
    logic [1:0]        respSt_q,   respSt_d;

`ifdef FP_ARB_ROUND_ROBIN_EN
    // Holds the id of the requester granted most recently.
    // Reset to 1 so requester 0 wins the first tie.
    logic              lastGrant_q, lastGrant_d;

    assign tieGoesTo0 = lastGrant_q;

    always_comb begin
        lastGrant_d = lastGrant_q;
        if (handshake) begin
            lastGrant_d = grant1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lastGrant_q <= 1'b1;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end
`else
    assign tieGoesTo0 = 1'b1;
`endif

    // Combinational grant. Reset forces both grants low so that nothing
    // can be accepted while the pipeline is being cleared.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst_i) begin
            if (req0_vld_i && (!req1_vld_i || tieGoesTo0)) begin
                grant0 = 1'b1;
            end else if (req1_vld_i) begin
                grant1 = 1'b1;
            end
        end
    end

    assign handshake = grant0 | grant1;

    // Next-state logic for the issue registers, the tag pipeline and the
    // response registers. The summator never stalls, so tags shift every
    // cycle. The operand registers keep their old value when idle.
    always_comb begin
        fpuVld_d   = handshake;
        fpuA_d     = fpuA_q;
        fpuB_d     = fpuB_q;
        if (grant1) begin
            fpuA_d = req1_a_i;
            fpuB_d = req1_b_i;
        end else if (grant0) begin
            fpuA_d = req0_a_i;
            fpuB_d = req0_b_i;
        end

        tagVld_d   = {tagVld_q[TAG_MSB-1:0], handshake};
        tagId_d    = {tagId_q[TAG_MSB-1:0], grant1};

        resp0Vld_d = tagVld_q[TAG_MSB] & ~tagId_q[TAG_MSB];
        resp1Vld_d = tagVld_q[TAG_MSB] &  tagId_q[TAG_MSB];
        respRes_d  = respRes_q;
        respSt_d   = respSt_q;
        if (tagVld_q[TAG_MSB]) begin
            respRes_d = fpu_res_i;
            respSt_d  = fpu_status_i;
        end
    end

    // Asynchronous reset drops every in-flight tag. Results that the
    // summator is still computing then return with no owner and are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fpuVld_q   <= 1'b0;
            fpuA_q     <= '0;
            fpuB_q     <= '0;
            tagVld_q   <= '0;
            tagId_q    <= '0;
            resp0Vld_q <= 1'b0;
            resp1Vld_q <= 1'b0;
            respRes_q  <= '0;
            respSt_q   <= 2'b00;
        end else begin
            fpuVld_q   <= fpuVld_d;
            fpuA_q     <= fpuA_d;
            fpuB_q     <= fpuB_d;
            tagVld_q   <= tagVld_d;
            tagId_q    <= tagId_d;
            resp0Vld_q <= resp0Vld_d;
            resp1Vld_q <= resp1Vld_d;
            respRes_q  <= respRes_d;
            respSt_q   <= respSt_d;
        end
    end

    assign req0_rdy_o    = grant0;
    assign req1_rdy_o    = grant1;
    assign fpu_vld_o     = fpuVld_q;
    assign fpu_a_o       = fpuA_q;
    assign fpu_b_o       = fpuB_q;
    assign resp0_vld_o   = resp0Vld_q;
    assign resp1_vld_o   = resp1Vld_q;
    assign resp_res_o    = respRes_q;
    assign resp_status_o = respSt_q;
    assign busy_o        = (|tagVld_q) | fpuVld_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_add_arbiter
//
// Self-checking bench for fp_add_arbiter. A behavioural summator with a
// fixed latency answers from a small table of known single-precision sums.
// Each handshake pushes two expectations into scoreboard queues:
//   - the operands and the cycle in which fpu_vld_o must appear
//   - the owner, result, status and cycle of the response strobe
// A monitor pops the queue entries when the DUT produces them.
// Build with +define+FP_ARB_ROUND_ROBIN_EN to exercise the round-robin tie.
// ---------------------------------------------------------------------------
module tb_fp_add_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_vld_i = 1'b0;
    logic [31:0] req0_a_i = '0;
    logic [31:0] req0_b_i = '0;
    logic        req0_rdy_o;
    logic        req1_vld_i = 1'b0;
    logic [31:0] req1_a_i = '0;
    logic [31:0] req1_b_i = '0;
    logic        req1_rdy_o;
    logic        resp0_vld_o;
    logic        resp1_vld_o;
    logic [31:0] resp_res_o;
    logic [1:0]  resp_status_o;
    logic        fpu_vld_o;
    logic [31:0] fpu_a_o;
    logic [31:0] fpu_b_o;
    logic [31:0] fpu_res_i;
    logic [1:0]  fpu_status_i;
    logic        busy_o;

    fp_add_arbiter #(.LATENCY(LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_vld_i   (req0_vld_i),
        .req0_a_i     (req0_a_i),
        .req0_b_i     (req0_b_i),
        .req0_rdy_o   (req0_rdy_o),
        .req1_vld_i   (req1_vld_i),
        .req1_a_i     (req1_a_i),
        .req1_b_i     (req1_b_i),
        .req1_rdy_o   (req1_rdy_o),
        .resp0_vld_o  (resp0_vld_o),
        .resp1_vld_o  (resp1_vld_o),
        .resp_res_o   (resp_res_o),
        .resp_status_o(resp_status_o),
        .fpu_vld_o    (fpu_vld_o),
        .fpu_a_o      (fpu_a_o),
        .fpu_b_o      (fpu_b_o),
        .fpu_res_i    (fpu_res_i),
        .fpu_status_i (fpu_status_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural summator: the pipe samples {vld,a,b} at every edge.
    // Entry LAT-1 is LAT cycles behind the fpu_vld_o cycle.
    logic [64:0] fpPipe [LAT];

    always @(posedge clk) begin
        fpPipe[0] <= {fpu_vld_o, fpu_a_o, fpu_b_o};
        for (int i = 1; i < LAT; i++) fpPipe[i] <= fpPipe[i-1];
    end

    function automatic logic [33:0] modelAdd(input logic [63:0] ab);
        case (ab)
            64'h3F600000_400CCCCD: return {2'b00, 32'h4044CCCD};
            64'h3F800000_3F800000: return {2'b00, 32'h40000000};
            64'h40000000_3F800000: return {2'b00, 32'h40400000};
            64'h3F800000_40000000: return {2'b00, 32'h40400000};
            64'h40400000_3F800000: return {2'b00, 32'h40800000};
            // Nonzero status here exercises the status return path.
            64'h40800000_3F800000: return {2'b01, 32'h40A00000};
            default:               return {2'b11, 32'hBAD0BAD0};
        endcase
    endfunction

    always_comb begin
        if (fpPipe[LAT-1][64]) {fpu_status_i, fpu_res_i} = modelAdd(fpPipe[LAT-1][63:0]);
        else                   {fpu_status_i, fpu_res_i} = {2'b11, 32'hDEADBEEF};
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } issue_t;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [1:0]  st;
        int          due;
    } resp_t;

    issue_t issueQ[$];
    resp_t  respQ[$];
    issue_t monIssue;
    resp_t  monResp;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Scoreboard monitor: compares everything the DUT issues or returns
    // against the front of the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (fpu_vld_o) begin
                if (issueQ.size() == 0) begin
                    checkOutput("fpuSpurious", 32'd1, 32'd0);
                end else begin
                    monIssue = issueQ.pop_front();
                    checkOutput("fpuA", fpu_a_o, monIssue.a);
                    checkOutput("fpuB", fpu_b_o, monIssue.b);
                    checkOutput("fpuCycle", cyc, monIssue.due);
                end
            end else if (issueQ.size() > 0 && issueQ[0].due <= cyc) begin
                checkOutput("fpuMissing", 32'd0, 32'd1);
                void'(issueQ.pop_front());
            end

            if (resp0_vld_o && resp1_vld_o) checkOutput("respBoth", 32'd1, 32'd0);
            if (resp0_vld_o || resp1_vld_o) begin
                if (respQ.size() == 0) begin
                    checkOutput("respSpurious", 32'd1, 32'd0);
                end else begin
                    monResp = respQ.pop_front();
                    checkOutput("respId", {31'd0, resp1_vld_o}, {31'd0, monResp.id});
                    checkOutput("respRes", resp_res_o, monResp.res);
                    checkOutput("respStatus", {30'd0, resp_status_o}, {30'd0, monResp.st});
                    checkOutput("respCycle", cyc, monResp.due);
                end
            end else if (respQ.size() > 0 && respQ[0].due <= cyc) begin
                checkOutput("respMissing", 32'd0, 32'd1);
                void'(respQ.pop_front());
            end
        end
    end

    // Drives one cycle of requests, checks the grant, and records the
    // expected issue and response for the requester that should win.
    // expGrant: 0 or 1 for a requester, any other value for no grant.
    task automatic applyStimulus(input string tag,
                                 input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                                 input int expGrant, input logic [31:0] expRes, input logic [1:0] expSt);
        @(negedge clk);
        req0_vld_i = v0; req0_a_i = a0; req0_b_i = b0;
        req1_vld_i = v1; req1_a_i = a1; req1_b_i = b1;
        #1;
        checkOutput({tag, "Rdy0"}, {31'd0, req0_rdy_o}, {31'd0, expGrant == 0});
        checkOutput({tag, "Rdy1"}, {31'd0, req1_rdy_o}, {31'd0, expGrant == 1});
        if (expGrant == 0) begin
            issueQ.push_back('{a: a0, b: b0, due: cyc + 1});
            respQ.push_back('{id: 1'b0, res: expRes, st: expSt, due: cyc + LAT + 2});
        end else if (expGrant == 1) begin
            issueQ.push_back('{a: a1, b: b1, due: cyc + 1});
            respQ.push_back('{id: 1'b1, res: expRes, st: expSt, due: cyc + LAT + 2});
        end
    endtask

    task automatic drain();
        @(negedge clk);
        req0_vld_i = 1'b0;
        req1_vld_i = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        #1;
        checkOutput("drainIssueQ", issueQ.size(), 32'd0);
        checkOutput("drainRespQ", respQ.size(), 32'd0);
        issueQ.delete();
        respQ.delete();
    endtask

    logic [31:0] b2bA   [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F600000};
    logic [31:0] b2bB   [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h400CCCCD};
    logic [31:0] b2bRes [5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h4044CCCD};
    logic [1:0]  b2bSt  [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
`ifdef FP_ARB_ROUND_ROBIN_EN
    int tieGrant [4] = '{0, 1, 0, 1};
`else
    int tieGrant [4] = '{0, 0, 0, 0};
`endif

    initial begin
        int pulses;
        int k;

        // Reset state, including grants held low despite valid requests.
        repeat (2) @(negedge clk);
        req0_vld_i = 1'b1;
        req1_vld_i = 1'b1;
        #1;
        checkOutput("rstRdy0", {31'd0, req0_rdy_o}, 32'd0);
        checkOutput("rstRdy1", {31'd0, req1_rdy_o}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy_o}, 32'd0);
        checkOutput("rstFpuVld", {31'd0, fpu_vld_o}, 32'd0);
        checkOutput("rstRes", resp_res_o, 32'd0);
        checkOutput("rstFpuA", fpu_a_o, 32'd0);
        req0_vld_i = 1'b0;
        req1_vld_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] idle");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            checkOutput("idleFpuVld", {31'd0, fpu_vld_o}, 32'd0);
            checkOutput("idleResp0", {31'd0, resp0_vld_o}, 32'd0);
            checkOutput("idleResp1", {31'd0, resp1_vld_o}, 32'd0);
            checkOutput("idleBusy", {31'd0, busy_o}, 32'd0);
        end

        $display("[TB] tie");
        for (int i = 0; i < 4; i++) begin
            applyStimulus("tie", 1'b1, 32'h3F800000, 32'h40000000,
                                 1'b1, 32'h3F800000, 32'h3F800000,
                                 tieGrant[i], (tieGrant[i] == 0) ? 32'h40400000 : 32'h40000000, 2'b00);
        end
        drain();

        $display("[TB] single");
        applyStimulus("single", 1'b1, 32'h3F600000, 32'h400CCCCD, 1'b0, 32'h0, 32'h0,
                      0, 32'h4044CCCD, 2'b00);
        drain();
        checkOutput("holdA", fpu_a_o, 32'h3F600000);
        checkOutput("holdB", fpu_b_o, 32'h400CCCCD);

        $display("[TB] back-to-back");
        for (int i = 0; i < 5; i++) begin
            applyStimulus("b2b", 1'b1, b2bA[i], b2bB[i], 1'b0, 32'h0, 32'h0, 0, b2bRes[i], b2bSt[i]);
            if (i > 0) checkOutput("b2bBusyIssue", {31'd0, busy_o}, 32'd1);
        end
        @(negedge clk);
        req0_vld_i = 1'b0;
        #1;
        pulses = 0;
        k = 0;
        while (pulses < 5 && k < 20) begin
            if (resp0_vld_o) begin
                pulses++;
                if (pulses < 5) checkOutput("b2bBusyPulse", {31'd0, busy_o}, 32'd1);
            end
            k++;
            if (pulses < 5) begin
                @(negedge clk);
                #1;
            end
        end
        checkOutput("b2bPulses", pulses, 32'd5);
        @(negedge clk);
        #1;
        checkOutput("b2bBusyAfter", {31'd0, busy_o}, 32'd0);
        checkOutput("b2bResp0After", {31'd0, resp0_vld_o}, 32'd0);
        drain();

        $display("[TB] reset mid-flight");
        applyStimulus("mid", 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h0, 32'h0, 0, 32'h40000000, 2'b00);
        applyStimulus("mid", 1'b1, 32'h40000000, 32'h3F800000, 1'b0, 32'h0, 32'h0, 0, 32'h40400000, 2'b00);
        @(negedge clk);
        req0_vld_i = 1'b0;
        rst = 1'b1;
        issueQ.delete();
        respQ.delete();
        #1;
        checkOutput("midBusy", {31'd0, busy_o}, 32'd0);
        checkOutput("midFpuVld", {31'd0, fpu_vld_o}, 32'd0);
        checkOutput("midFpuA", fpu_a_o, 32'd0);
        checkOutput("midFpuB", fpu_b_o, 32'd0);
        checkOutput("midRes", resp_res_o, 32'd0);
        checkOutput("midStatus", {30'd0, resp_status_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            checkOutput("midResp0", {31'd0, resp0_vld_o}, 32'd0);
            checkOutput("midResp1", {31'd0, resp1_vld_o}, 32'd0);
            checkOutput("midBusyAfter", {31'd0, busy_o}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
